// File: rtl/nibble_alu_sequencer_pkg.sv
// Shared types for the nibble-serial ALU sequencer.
// Nibble width, sequencer states and ALU command encodings.
package nibble_alu_sequencer_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int NIBBLES_DEF = 8;
  localparam int CMD_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } SeqState;

  typedef logic [$clog2(NIBBLES_DEF)-1:0] NibbleIdx;

  typedef logic [CMD_W_DEF-1:0] AluCmd;

  typedef enum logic [CMD_W_DEF-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4
  } AluCtrl;

endpackage

// File: rtl/nibble_alu_sequencer_idx_counter.sv
// Resettable nibble index counter with clear, enable and terminal count.
// Wraps to zero on the enabled terminal-count edge.
module nibble_idx_counter #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         tc
);

  logic [W-1:0] idx_q;

  assign idx = idx_q;
  assign tc  = (idx_q == W'(MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (en) begin
      idx_q <= tc ? '0 : idx_q + W'(1);
    end
  end

endmodule

// File: rtl/nibble_alu_sequencer.sv
// Runs a 4-bit ALU over a full word, one nibble per cycle, LSB first.
// Latches the request, ripples carry, and returns result/carry/zero.
module nibble_alu_sequencer
  import nibble_alu_sequencer_pkg::*;
#(
  parameter  int NIBBLES = 8,
  parameter  int CMD_W   = 4,
  localparam int WORD_W  = NIBBLES * NIBBLE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic              req_carry_in,
  output logic [3:0]        alu_d1,
  output logic [3:0]        alu_d2,
  output logic [CMD_W-1:0]  alu_cmd,
  output logic              alu_carry_in,
  input  logic [3:0]        alu_res,
  input  logic              alu_carry_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  SeqState state_q, state_d;

  logic [WORD_W-1:0] a_q, b_q, result_q, result_d;
  logic [CMD_W-1:0]  cmd_q;
  logic              carry_q;
  logic              zero_q;
  logic [IDX_W-1:0]  idx;
  logic              tc;
  logic              accept;
  logic              run;

  nibble_idx_counter #(
    .W   (IDX_W),
    .MAX (NIBBLES - 1)
  ) u_idx (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (run),
    .idx   (idx),
    .tc    (tc)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    run       = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (tc) state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Insert the ALU nibble at the current index
  always_comb begin
    result_d = result_q;
    result_d[idx*NIBBLE_W +: NIBBLE_W] = alu_res;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      cmd_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_q      <= req_a;
      b_q      <= req_b;
      cmd_q    <= req_cmd;
      carry_q  <= req_carry_in;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (run) begin
      result_q <= result_d;
      carry_q  <= alu_carry_out;
      if (tc) zero_q <= (result_d == '0);
    end
  end

  // Operand nibbles are gated outside RUN to keep the ALU quiet
  assign alu_d1       = run ? a_q[idx*NIBBLE_W +: NIBBLE_W] : 4'h0;
  assign alu_d2       = run ? b_q[idx*NIBBLE_W +: NIBBLE_W] : 4'h0;
  assign alu_carry_in = run & carry_q;
  assign alu_cmd      = cmd_q;

  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign rsp_zero   = zero_q;

endmodule
